// File: rtl/neuron_layer_mac.sv
// Fully-connected layer engine: one neuron at a time, LANES signed MACs per cycle.
// Each neuron's result is rounded, optionally ReLU'd, saturated, and then handed off over a valid/ready port.
module neuron_layer_mac #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int LANES       = 2,
  parameter int X_W         = 8,
  parameter int W_W         = 8,
  parameter int B_W         = 16,
  parameter int OUT_W       = 16,
  parameter int GUARD_BITS  = 2,
  parameter int SHIFT       = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    relu_en,
  input  logic [NUM_INPUTS*X_W-1:0]               x_flat,
  input  logic [NUM_NEURONS*NUM_INPUTS*W_W-1:0]   w_flat,
  input  logic [NUM_NEURONS*B_W-1:0]              bias_flat,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [OUT_W-1:0]                        out_data,
  output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] out_idx,
  output logic                                    out_last,
  output logic                                    busy
);
  localparam int ACC_A  = X_W + W_W + $clog2(NUM_INPUTS) + GUARD_BITS;
  localparam int ACC_W  = (ACC_A > B_W + 1) ? ACC_A : B_W + 1;
  localparam int IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CH     = NUM_INPUTS / LANES;
  localparam int CNT_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int EXT_W  = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_next;

  logic [NUM_INPUTS*X_W-1:0]             x_reg;
  logic [NUM_NEURONS*NUM_INPUTS*W_W-1:0] w_reg;
  logic [NUM_NEURONS*B_W-1:0]            b_reg;
  logic                                  relu_reg;
  logic signed [ACC_W-1:0]               acc, acc_next;
  logic [IDX_W-1:0]                      idx, idx_inc;
  logic [CNT_W-1:0]                      cnt;
  logic                                  last_chunk;
  logic signed [X_W+W_W-1:0]             prod [LANES];

  function automatic logic signed [ACC_W-1:0] sext_b(input logic [B_W-1:0] b);
    return {{(ACC_W-B_W){b[B_W-1]}}, b};
  endfunction

  // Round-half-up shift, then ReLU, then clamp into the signed output range.
  function automatic logic [OUT_W-1:0] post(input logic signed [ACC_W-1:0] a, input logic relu);
    logic signed [EXT_W-1:0] v;
    v = EXT_W'(a);
    if (SHIFT > 0) begin
      v = v + (EXT_W'(1) <<< RND_SH);
      v = v >>> SHIFT;
    end
    if (relu && v < 0) v = '0;
    if (v[EXT_W-1:OUT_W-1] != {(EXT_W-OUT_W+1){v[EXT_W-1]}})
      post = v[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      post = v[OUT_W-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [X_W-1:0] xe;
      logic signed [W_W-1:0] we;
      assign xe = x_reg[(int'(cnt)*LANES + gi)*X_W +: X_W];
      assign we = w_reg[(int'(idx)*NUM_INPUTS + int'(cnt)*LANES + gi)*W_W +: W_W];
      assign prod[gi] = xe * we;
    end
  endgenerate

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < LANES; i++) acc_next = acc_next + ACC_W'(prod[i]);
  end

  assign last_chunk = (cnt == CNT_W'(CH - 1));
  assign idx_inc    = idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (last_chunk) state_next = OUT;
      OUT:     if (out_ready) state_next = out_last ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg     <= '0;
      w_reg     <= '0;
      b_reg     <= '0;
      relu_reg  <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_reg    <= x_flat;
          w_reg    <= w_flat;
          b_reg    <= bias_flat;
          relu_reg <= relu_en;
          acc      <= sext_b(bias_flat[B_W-1:0]);
          idx      <= '0;
          cnt      <= '0;
        end
        MAC: begin
          acc <= acc_next;
          if (last_chunk) begin
            cnt       <= '0;
            out_data  <= post(acc_next, relu_reg);
            out_idx   <= idx;
            out_last  <= (idx == IDX_W'(NUM_NEURONS - 1));
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (!out_last) begin
            idx <= idx_inc;
            acc <= sext_b(b_reg[int'(idx_inc)*B_W +: B_W]);
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_layer_mac.sv
// Scoreboard bench for neuron_layer_mac: default instance plus a SHIFT=2 instance for rounding.
module tb_neuron_layer_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, relu_en, out_valid, out_ready, out_last, busy;
  logic [63:0]  x_flat, bias_flat;
  logic [255:0] w_flat;
  logic [15:0]  out_data;
  logic [1:0]   out_idx;

  logic         s_in_valid, s_in_ready, s_relu_en, s_out_valid, s_out_ready, s_out_last, s_busy;
  logic [63:0]  s_x_flat, s_bias_flat;
  logic [255:0] s_w_flat;
  logic [15:0]  s_out_data;
  logic [1:0]   s_out_idx;

  neuron_layer_mac dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .relu_en(relu_en),
    .x_flat(x_flat), .w_flat(w_flat), .bias_flat(bias_flat), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  neuron_layer_mac #(.SHIFT(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .relu_en(s_relu_en),
    .x_flat(s_x_flat), .w_flat(s_w_flat), .bias_flat(s_bias_flat), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_idx(s_out_idx), .out_last(s_out_last),
    .busy(s_busy)
  );

  typedef struct { int data; int idx; int last; } exp_t;
  exp_t q_a[$];
  exp_t q_s[$];
  int tests = 0;
  int fails = 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_a(int d0, int d1, int d2, int d3);
    q_a.push_back('{d0, 0, 0}); q_a.push_back('{d1, 1, 0});
    q_a.push_back('{d2, 2, 0}); q_a.push_back('{d3, 3, 1});
  endtask

  task automatic expect_s(int d0, int d1, int d2, int d3);
    q_s.push_back('{d0, 0, 0}); q_s.push_back('{d1, 1, 0});
    q_s.push_back('{d2, 2, 0}); q_s.push_back('{d3, 3, 1});
  endtask

  task automatic load_a(int xv, int wv, int b0, int b1, int b2, int b3);
    for (int i = 0; i < 8; i++)  x_flat[i*8 +: 8] = 8'(xv);
    for (int j = 0; j < 32; j++) w_flat[j*8 +: 8] = 8'(wv);
    bias_flat = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
  endtask

  task automatic send_a();
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("in_ready_before_send", int'(in_ready), 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen high (at least one edge).
  task automatic wait_valid(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 60);
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL wait_valid timeout after %0d cycles", n);
    end
  endtask

  task automatic drain_a();
    int n = 0;
    while (q_a.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("drain_a_pending", q_a.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: got data %0d idx %0d, required none", $signed(out_data), out_idx);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        $display("[TB] out idx=%0d data=%0d last=%0d", out_idx, $signed(out_data), out_last);
        check("out_data", int'($signed(out_data)), e.data);
        check("out_idx", int'(out_idx), e.idx);
        check("out_last", int'(out_last), e.last);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_out_valid && s_out_ready) begin
      if (q_s.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out_s: got data %0d, required none", $signed(s_out_data));
      end else begin
        exp_t e;
        e = q_s.pop_front();
        $display("[TB] shift out idx=%0d data=%0d", s_out_idx, $signed(s_out_data));
        check("s_out_data", int'($signed(s_out_data)), e.data);
        check("s_out_idx", int'(s_out_idx), e.idx);
        check("s_out_last", int'(s_out_last), e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    in_valid = 0; relu_en = 0; out_ready = 1; x_flat = '0; w_flat = '0; bias_flat = '0;
    s_in_valid = 0; s_relu_en = 0; s_out_ready = 1; s_x_flat = '0; s_w_flat = '0; s_bias_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("in_ready_after_rst", int'(in_ready), 1);

    // Basic transaction with latency and spacing
    load_a(1, 1, 0, 10, -3, 100);
    expect_a(8, 18, 5, 108);
    send_a();
    wait_valid(n);
    check("first_latency", n, 4);
    for (int k = 1; k < 4; k++) begin
      wait_valid(n);
      check("result_spacing", n, 5);
    end
    check("in_ready_at_last", int'(in_ready), 0);
    @(posedge clk); #1;
    check("busy_after_last", int'(busy), 0);
    drain_a();

    // Saturation and ReLU; relu_en is dropped after accept to confirm it was captured
    load_a(-128, 127, 0, 0, 0, 0);
    expect_a(-32768, -32768, -32768, -32768);
    send_a(); drain_a();
    relu_en = 1;
    expect_a(0, 0, 0, 0);
    send_a();
    relu_en = 0;
    drain_a();
    load_a(127, 127, 32767, 32767, 32767, 32767);
    expect_a(32767, 32767, 32767, 32767);
    send_a(); drain_a();

    // Backpressure at neuron 1
    load_a(1, 1, 0, 10, -3, 100);
    expect_a(8, 18, 5, 108);
    send_a();
    wait_valid(n);
    @(posedge clk); #1;
    out_ready = 0;
    wait_valid(n);
    check("bp_latency", n, 4);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", int'(out_valid), 1);
      check("bp_data_hold", int'($signed(out_data)), 18);
      check("bp_idx_hold", int'(out_idx), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1;
    wait_valid(n);
    check("bp_release_latency", n, 5);
    drain_a();

    // in_valid with other data while busy is ignored
    load_a(2, 1, 1, 2, 3, 4);
    expect_a(17, 18, 19, 20);
    send_a();
    repeat (2) begin @(posedge clk); #1; end
    load_a(5, 3, 100, 100, 100, 100);
    relu_en = 1;
    in_valid = 1;
    check("busy_in_ready", int'(in_ready), 0);
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 0;
    relu_en = 0;
    drain_a();

    // Reset during MAC of neuron 2
    load_a(1, 1, 0, 10, -3, 100);
    expect_a(8, 18, 5, 108);
    send_a();
    wait_valid(n);
    wait_valid(n);
    @(posedge clk); #2;
    rst_n = 0;
    q_a.delete();
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_out_idx", int'(out_idx), 0);
    check("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("in_ready_after_midrst", int'(in_ready), 1);
    expect_a(8, 18, 5, 108);
    send_a(); drain_a();

    // Rounding on the SHIFT=2 instance: totals 6, -6, 5, -5
    for (int i = 0; i < 8; i++) s_x_flat[i*8 +: 8] = 8'd1;
    for (int nn = 0; nn < 4; nn++)
      for (int i = 0; i < 8; i++)
        s_w_flat[(nn*8 + i)*8 +: 8] = (nn == 0 && i < 6) ? 8'd1 : 8'd0;
    s_bias_flat = {16'(-5), 16'(5), 16'(-6), 16'(0)};
    expect_s(2, -1, 1, -1);
    check("s_in_ready", int'(s_in_ready), 1);
    s_in_valid = 1;
    @(posedge clk); #1;
    s_in_valid = 0;
    n = 0;
    while (q_s.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("drain_s_pending", q_s.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
